// File: rtl/hazard_decoder.sv
// hazard_decoder: scans an 8x4 occupancy grid, one cell per clock, and merges
// horizontally contiguous occupied cells in a row into one bounding box. Boxes
// stream out over valid/ready; the frame ends with a one-cycle done pulse that
// carries the hazard count.
module hazard_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] vec1,
    input  logic [15:0] vec2,
    output logic        busy,
    output logic        box_valid,
    input  logic        box_ready,
    output logic [10:0] box_top,
    output logic [10:0] box_left,
    output logic [10:0] box_bottom,
    output logic [10:0] box_right,
    output logic [3:0]  box_idx,
    output logic        done,
    output logic [4:0]  num_hazards,
    output logic        overflow
);

    localparam int unsigned COLS      = 8;
    localparam int unsigned ROWS      = 4;
    localparam int unsigned CELL_W    = 160;
    localparam int unsigned CELL_H    = 180;
    localparam int unsigned MAX_HAZ   = 16;
    localparam int unsigned CELLS     = COLS * ROWS;
    localparam int unsigned CELL_IW   = 5;
    localparam int unsigned COL_W     = 3;
    localparam int unsigned ROW_W     = 2;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned COORD_W   = 11;

    localparam logic [CELL_IW-1:0] LAST_CELL = CELL_IW'(CELLS - 1);
    localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_HAZ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [CELLS-1:0]     r_grid;
    logic [CELL_IW-1:0]   r_cell;
    logic                 r_run_open;
    logic [COL_W-1:0]     r_run_start;
    logic [CNT_W-1:0]     r_count;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_box_valid;
    logic [COORD_W-1:0]   r_box_top;
    logic [COORD_W-1:0]   r_box_left;
    logic [COORD_W-1:0]   r_box_bottom;
    logic [COORD_W-1:0]   r_box_right;
    logic [3:0]           r_box_idx;
    logic                 r_done;
    logic [CNT_W-1:0]     r_num_hazards;
    logic                 r_overflow;

    state_t               w_state_nxt;
    logic [CELLS-1:0]     w_grid_nxt;
    logic [CELL_IW-1:0]   w_cell_nxt;
    logic                 w_run_open_nxt;
    logic [COL_W-1:0]     w_run_start_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_last_nxt;
    logic                 w_busy_nxt;
    logic                 w_box_valid_nxt;
    logic [COORD_W-1:0]   w_box_top_nxt;
    logic [COORD_W-1:0]   w_box_left_nxt;
    logic [COORD_W-1:0]   w_box_bottom_nxt;
    logic [COORD_W-1:0]   w_box_right_nxt;
    logic [3:0]           w_box_idx_nxt;
    logic                 w_done_nxt;
    logic [CNT_W-1:0]     w_num_hazards_nxt;
    logic                 w_overflow_nxt;

    logic                 w_occ;
    logic [COL_W-1:0]     w_col;
    logic [ROW_W-1:0]     w_row;
    logic                 w_close;
    logic [COL_W-1:0]     w_close_start;
    logic [COL_W-1:0]     w_close_end;

    // Current cell decode: grid bit index equals row*COLS + col
    always_comb begin
        w_occ = r_grid[r_cell];
        w_col = r_cell[COL_W-1:0];
        w_row = r_cell[CELL_IW-1:COL_W];
    end

    // Next-state, run tracking and registered-output next values
    always_comb begin
        w_state_nxt       = r_state;
        w_grid_nxt        = r_grid;
        w_cell_nxt        = r_cell;
        w_run_open_nxt    = r_run_open;
        w_run_start_nxt   = r_run_start;
        w_count_nxt       = r_count;
        w_last_nxt        = r_last;
        w_box_valid_nxt   = r_box_valid;
        w_box_top_nxt     = r_box_top;
        w_box_left_nxt    = r_box_left;
        w_box_bottom_nxt  = r_box_bottom;
        w_box_right_nxt   = r_box_right;
        w_box_idx_nxt     = r_box_idx;
        w_done_nxt        = 1'b0;
        w_num_hazards_nxt = r_num_hazards;
        w_overflow_nxt    = r_overflow;
        w_close           = 1'b0;
        w_close_start     = r_run_start;
        w_close_end       = w_col;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_grid_nxt        = {vec2, vec1};
                    w_cell_nxt        = '0;
                    w_run_open_nxt    = 1'b0;
                    w_run_start_nxt   = '0;
                    w_count_nxt       = '0;
                    w_last_nxt        = 1'b0;
                    w_overflow_nxt    = 1'b0;
                    w_num_hazards_nxt = '0;
                    w_state_nxt       = S_SCAN;
                end
            end

            S_SCAN: begin
                w_cell_nxt = r_cell + CELL_IW'(1);
                w_last_nxt = (r_cell == LAST_CELL);

                if (w_occ) begin
                    if (!r_run_open) begin
                        w_close_start   = w_col;
                        w_run_start_nxt = w_col;
                    end
                    // A row end closes the run on its last occupied cell
                    if (w_col == LAST_COL) begin
                        w_close        = 1'b1;
                        w_close_end    = w_col;
                        w_run_open_nxt = 1'b0;
                    end else begin
                        w_run_open_nxt = 1'b1;
                    end
                end else if (r_run_open) begin
                    w_close        = 1'b1;
                    w_close_end    = w_col - COL_W'(1);
                    w_run_open_nxt = 1'b0;
                end

                if (w_close) begin
                    if (r_count < MAX_CNT) begin
                        w_box_top_nxt    = COORD_W'(COORD_W'(w_row) * COORD_W'(CELL_H));
                        w_box_left_nxt   = COORD_W'(COORD_W'(w_close_start) * COORD_W'(CELL_W));
                        w_box_bottom_nxt = COORD_W'(COORD_W'(COORD_W'(w_row) + COORD_W'(1))
                                           * COORD_W'(CELL_H)) - COORD_W'(1);
                        w_box_right_nxt  = COORD_W'(COORD_W'(COORD_W'(w_close_end) + COORD_W'(1))
                                           * COORD_W'(CELL_W)) - COORD_W'(1);
                        w_box_idx_nxt    = r_count[3:0];
                        w_box_valid_nxt  = 1'b1;
                        w_state_nxt      = S_EMIT;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                end

                if ((w_state_nxt == S_SCAN) && (r_cell == LAST_CELL)) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_EMIT: begin
                if (box_ready) begin
                    w_count_nxt     = r_count + CNT_W'(1);
                    w_box_valid_nxt = 1'b0;
                    w_state_nxt     = r_last ? S_DONE : S_SCAN;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Done pulse and count are registered on entry to DONE
        if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
            w_done_nxt        = 1'b1;
            w_num_hazards_nxt = w_count_nxt;
        end

        w_busy_nxt = (w_state_nxt == S_SCAN) || (w_state_nxt == S_EMIT);
    end

    // State and datapath registers; reset discards any pending box
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grid        <= '0;
            r_cell        <= '0;
            r_run_open    <= 1'b0;
            r_run_start   <= '0;
            r_count       <= '0;
            r_last        <= 1'b0;
            r_busy        <= 1'b0;
            r_box_valid   <= 1'b0;
            r_box_top     <= '0;
            r_box_left    <= '0;
            r_box_bottom  <= '0;
            r_box_right   <= '0;
            r_box_idx     <= '0;
            r_done        <= 1'b0;
            r_num_hazards <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grid        <= w_grid_nxt;
            r_cell        <= w_cell_nxt;
            r_run_open    <= w_run_open_nxt;
            r_run_start   <= w_run_start_nxt;
            r_count       <= w_count_nxt;
            r_last        <= w_last_nxt;
            r_busy        <= w_busy_nxt;
            r_box_valid   <= w_box_valid_nxt;
            r_box_top     <= w_box_top_nxt;
            r_box_left    <= w_box_left_nxt;
            r_box_bottom  <= w_box_bottom_nxt;
            r_box_right   <= w_box_right_nxt;
            r_box_idx     <= w_box_idx_nxt;
            r_done        <= w_done_nxt;
            r_num_hazards <= w_num_hazards_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    assign busy        = r_busy;
    assign box_valid   = r_box_valid;
    assign box_top     = r_box_top;
    assign box_left    = r_box_left;
    assign box_bottom  = r_box_bottom;
    assign box_right   = r_box_right;
    assign box_idx     = r_box_idx;
    assign done        = r_done;
    assign num_hazards = r_num_hazards;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_hazard_decoder.sv
// Scoreboard bench for hazard_decoder: a row/run reference model fills an
// expected-box queue per frame; a negedge monitor pops and compares on every
// handshake and checks the done summary.
module tb_hazard_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] vec1 = '0;
    logic [15:0] vec2 = '0;
    logic        busy;
    logic        box_valid;
    logic        box_ready = 1'b0;
    logic [10:0] box_top, box_left, box_bottom, box_right;
    logic [3:0]  box_idx;
    logic        done;
    logic [4:0]  num_hazards;
    logic        overflow;

    hazard_decoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec1(vec1), .vec2(vec2),
        .busy(busy), .box_valid(box_valid), .box_ready(box_ready),
        .box_top(box_top), .box_left(box_left), .box_bottom(box_bottom),
        .box_right(box_right), .box_idx(box_idx), .done(done),
        .num_hazards(num_hazards), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int top; int left; int bottom; int right; int idx; int vcyc;
    } box_t;

    box_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   exp_cnt = 0;
    bit   exp_ovf = 1'b0;
    int   rmode = 0;
    int   stall = 0;
    bit   frame_done = 1'b0;
    bit   chk_timing = 1'b0;
    bit   hold_valid = 1'b0;
    logic [10:0] h_top, h_left, h_bottom, h_right;
    logic [3:0]  h_idx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk each row, collect maximal runs of set bits
    task automatic model(input logic [15:0] v1, input logic [15:0] v2);
        logic [31:0] g;
        int n;
        int c;
        int s;
        int close_cell;
        box_t b;
        g = {v2, v1};
        n = 0;
        exp_ovf = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 4; r++) begin
            c = 0;
            while (c < 8) begin
                if (g[r*8 + c]) begin
                    s = c;
                    while (c < 8 && g[r*8 + c]) c++;
                    close_cell = r*8 + ((c == 8) ? 7 : c);
                    if (n < 16) begin
                        b.top = r*180; b.left = s*160;
                        b.bottom = r*180 + 179; b.right = c*160 - 1;
                        b.idx = n; b.vcyc = close_cell + 2 + n;
                        exp_q.push_back(b);
                        n++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end else begin
                    c++;
                end
            end
        end
        exp_cnt = n;
    endtask

    // Consumer: 0 always ready, 1 three stall cycles per box, 2 random, 3 never
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: box_ready = 1'b1;
            1: begin
                if (!box_valid) begin
                    stall = 0;
                    box_ready = 1'b0;
                end else if (stall < 3) begin
                    stall++;
                    box_ready = 1'b0;
                end else begin
                    box_ready = 1'b1;
                end
            end
            2: box_ready = 1'($urandom_range(0, 1));
            default: box_ready = 1'b0;
        endcase
    end

    // Monitor: stability while stalled, field compare on handshake, done summary
    always @(negedge clk) begin
        box_t e;
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (box_valid) begin
                if (hold_valid) begin
                    check("stable_top", int'(box_top), int'(h_top));
                    check("stable_left", int'(box_left), int'(h_left));
                    check("stable_bottom", int'(box_bottom), int'(h_bottom));
                    check("stable_right", int'(box_right), int'(h_right));
                    check("stable_idx", int'(box_idx), int'(h_idx));
                end else if (chk_timing && exp_q.size() > 0) begin
                    check("valid_cycle", cyc - start_cyc, exp_q[0].vcyc);
                end
                if (box_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_box: got idx %0d expected none", box_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("box_top", int'(box_top), e.top);
                        check("box_left", int'(box_left), e.left);
                        check("box_bottom", int'(box_bottom), e.bottom);
                        check("box_right", int'(box_right), e.right);
                        check("box_idx", int'(box_idx), e.idx);
                    end
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    h_top = box_top; h_left = box_left; h_bottom = box_bottom;
                    h_right = box_right; h_idx = box_idx;
                end
            end else begin
                hold_valid = 1'b0;
            end
            if (done) begin
                check("num_hazards", int'(num_hazards), exp_cnt);
                check("overflow", int'(overflow), int'(exp_ovf));
                check("boxes_left", exp_q.size(), 0);
                check("busy_at_done", int'(busy), 0);
                if (chk_timing) check("done_cycle", cyc - start_cyc, 33 + exp_cnt);
                frame_done = 1'b1;
            end
        end
    end

    task automatic pulse_start(input logic [15:0] v1, input logic [15:0] v2);
        @(posedge clk); #2;
        vec1 = v1; vec2 = v2; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] v1, input logic [15:0] v2, input int mode);
        rmode = mode;
        chk_timing = (mode == 0);
        model(v1, v2);
        frame_done = 1'b0;
        @(posedge clk); #2;
        vec1 = v1; vec2 = v2; start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 2000 && !frame_done; i++) @(posedge clk);
        if (!frame_done) begin
            n_vec++; n_err++;
            $display("FAIL frame_timeout: got no done expected done within 2000 cycles");
        end
        @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(box_valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_nh"}, int'(num_hazards), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_fields"}, int'({box_top, box_left, box_bottom, box_right, box_idx}), 0);
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        run_frame(16'h0000, 16'h0000, 0);
        run_frame(16'h0001, 16'h0000, 0);
        run_frame(16'h0000, 16'hE000, 0);
        run_frame(16'h00FF, 16'h0000, 0);
        run_frame(16'h5555, 16'h5555, 1);
        run_frame(16'hFFFF, 16'hFFFF, 0);

        // Ignored mid-scan start, then reset while a box is stalled
        rmode = 3;
        chk_timing = 1'b0;
        model(16'hFF00, 16'h0000);
        pulse_start(16'hFF00, 16'h0000);
        repeat (4) @(posedge clk);
        pulse_start(16'h000F, 16'hFFFF);
        waited = 0;
        while (!box_valid && waited < 100) begin
            @(posedge clk); #2;
            waited++;
        end
        check("t6_valid_seen", int'(box_valid), 1);
        check("t6_top", int'(box_top), exp_q[0].top);
        check("t6_left", int'(box_left), exp_q[0].left);
        check("t6_bottom", int'(box_bottom), exp_q[0].bottom);
        check("t6_right", int'(box_right), exp_q[0].right);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_frame(16'h0F0F, 16'h8001, 0);

        for (int k = 0; k < 20; k++) begin
            run_frame(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
